// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_pkg                                                  |
// | Brief    : Shared UART state encoding and parity mode constants.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Mode 2'b11 is deliberately treated like PAR_NONE.
  function automatic logic par_active(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_sync_fifo                                            |
// | Brief    : Single-clock show-ahead FIFO, power-of-two depth.         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_DEPTH = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == c_DEPTH);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx_frame                                             |
// | Brief    : FIFO-fed UART transmitter, runtime parity / stop format.  |
// |            UART_TX_FRAME_PARITY_EN builds the parity bit support.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_tx_frame #(
  parameter int DBIT       = 8,
  parameter int OS_TICK    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_tick,
  input  logic                          in_valid,
  input  logic [DBIT-1:0]               in_data,
  output logic                          in_ready,
  input  logic [1:0]                    par_mode,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done_tick,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import uart_pkg::*;

  localparam int c_TW = $clog2(2*OS_TICK);
  localparam int c_BW = $clog2(DBIT);
  localparam logic [c_TW-1:0] c_TICK_LAST  = c_TW'(OS_TICK-1);
  localparam logic [c_TW-1:0] c_TICK_LAST2 = c_TW'(2*OS_TICK-1);
  localparam logic [c_BW-1:0] c_BIT_LAST   = c_BW'(DBIT-1);

  tx_state_e        r_state;
  tx_state_e        w_state_n;
  logic [c_TW-1:0]  r_tick;
  logic [c_TW-1:0]  w_tick_n;
  logic [c_BW-1:0]  r_bit;
  logic [c_BW-1:0]  w_bit_n;
  logic [DBIT-1:0]  r_shift;
  logic [DBIT-1:0]  w_shift_n;
  logic             r_tx;
  logic             w_tx_n;
  logic             r_stop2;
  logic             w_pop;
  logic             w_done;
  logic             w_full;
  logic             w_empty;
  logic [DBIT-1:0]  w_fifo_data;
  logic             w_tick_end;
  logic             w_stop_end;

`ifdef UART_TX_FRAME_PARITY_EN
  logic             r_par_en;
  logic             r_par_bit;
`else
  logic             w_unused_par_mode;
  assign w_unused_par_mode = ^par_mode;
`endif

  uart_sync_fifo #(
    .WIDTH (DBIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (in_valid),
    .i_wr_data (in_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (fifo_count)
  );

  assign in_ready     = !w_full;
  assign busy         = (r_state != IDLE);
  assign tx           = r_tx;
  assign tx_done_tick = w_done && !rst;
  assign w_tick_end   = s_tick && (r_tick == c_TICK_LAST);
  assign w_stop_end   = s_tick && (r_tick == (r_stop2 ? c_TICK_LAST2 : c_TICK_LAST));

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_bit_n   = r_bit;
    w_tick_n  = s_tick ? r_tick + 1'b1 : r_tick;
    w_pop     = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick_n = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_fifo_data;
          w_state_n = START;
        end
      end
      START: begin
        if (w_tick_end) begin
          w_state_n = DATA;
          w_bit_n   = '0;
          w_tick_n  = '0;
        end
      end
      DATA: begin
        if (w_tick_end) begin
          w_shift_n = r_shift >> 1;
          w_tick_n  = '0;
          if (r_bit == c_BIT_LAST) begin
`ifdef UART_TX_FRAME_PARITY_EN
            w_state_n = r_par_en ? PARITY : STOP;
`else
            w_state_n = STOP;
`endif
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end
      end
`ifdef UART_TX_FRAME_PARITY_EN
      PARITY: begin
        if (w_tick_end) begin
          w_state_n = STOP;
          w_tick_n  = '0;
        end
      end
`endif
      STOP: begin
        if (w_stop_end) begin
          w_done   = 1'b1;
          w_tick_n = '0;
          // Back-to-back streaming: the next start bit follows without an idle cycle.
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_n = w_fifo_data;
            w_state_n = START;
          end else begin
            w_state_n = IDLE;
          end
        end
      end
      default: begin
        w_state_n = IDLE;
        w_tick_n  = '0;
      end
    endcase
  end

  // The line level is derived from the upcoming state so the pin is glitch-free
  // and changes on the same edge as the state register.
  always_comb begin
    w_tx_n = 1'b1;
    case (w_state_n)
      START:   w_tx_n = 1'b0;
      DATA:    w_tx_n = w_shift_n[0];
`ifdef UART_TX_FRAME_PARITY_EN
      PARITY:  w_tx_n = r_par_bit;
`endif
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_stop2 <= 1'b0;
`ifdef UART_TX_FRAME_PARITY_EN
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      if (w_pop) begin
        r_stop2 <= stop2;
`ifdef UART_TX_FRAME_PARITY_EN
        r_par_en  <= par_active(par_mode);
        r_par_bit <= (^w_fifo_data) ^ (par_mode == PAR_ODD);
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_tx_frame                                          |
// | Brief    : Randomised self-checking bench against a bit-list model.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_tx_frame;

  localparam int DBIT  = 8;
  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_FRAME_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_tick = 1'b0;
  logic            in_valid = 1'b0;
  logic [DBIT-1:0] in_data = '0;
  logic            in_ready;
  logic [1:0]      par_mode = 2'b00;
  logic            stop2 = 1'b0;
  logic            tx;
  logic            busy;
  logic            tx_done_tick;
  logic [CW-1:0]   fifo_count;

  int errors = 0;
  int checks = 0;
  int tick_mode = 0;
  int tick_den = 2;

  bit q_line[$];
  int q_done[$];
  bit q_exp[$];
  int q_exp_done[$];
  int gap_cnt = 0;
  bit gap_en = 1'b0;
  int gap_target = 0;

  uart_tx_frame #(
    .DBIT       (DBIT),
    .OS_TICK    (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .par_mode     (par_mode),
    .stop2        (stop2),
    .tx           (tx),
    .busy         (busy),
    .tx_done_tick (tx_done_tick),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tick_mode)
        0:       s_tick = 1'b1;
        1:       s_tick = 1'b0;
        default: s_tick = (($urandom % tick_den) == 0);
      endcase
    end
  end

  // One line sample per counted tick while a frame is in flight.
  always @(negedge clk) begin
    if (busy && s_tick) q_line.push_back(tx);
    if (tx_done_tick) q_done.push_back(q_line.size());
    if (gap_en && !busy && (q_done.size() < gap_target)) gap_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void clear_all();
    q_line.delete();
    q_done.delete();
    q_exp.delete();
    q_exp_done.delete();
  endfunction

  // Expected line: every symbol held OS ticks, LSB-first data.
  function automatic void add_frame(input logic [DBIT-1:0] w, input logic [1:0] pm, input logic st2);
    bit par_on;
    bit par_bit;
    par_on  = PAR_BUILT && ((pm == 2'b01) || (pm == 2'b10));
    par_bit = (^w) ^ (pm == 2'b10);
    repeat (OS) q_exp.push_back(1'b0);
    for (int i = 0; i < DBIT; i++) repeat (OS) q_exp.push_back(w[i]);
    if (par_on) repeat (OS) q_exp.push_back(par_bit);
    repeat (OS * (st2 ? 2 : 1)) q_exp.push_back(1'b1);
    q_exp_done.push_back(q_exp.size());
  endfunction

  task automatic push(input logic [DBIT-1:0] w, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 5000) begin
      cyc(1);
      n++;
    end
    ok = in_ready;
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int c;
    c = 0;
    while (q_done.size() < n && c < 20000) begin
      cyc(1);
      c++;
    end
    chk({tag, "_wait"}, int'(c < 20000), 1);
    cyc(3);
  endtask

  task automatic check_line(input string tag);
    int bad;
    int dbad;
    int m;
    bad  = 0;
    dbad = 0;
    chk({tag, "_len"}, q_line.size(), q_exp.size());
    m = (q_line.size() < q_exp.size()) ? q_line.size() : q_exp.size();
    for (int i = 0; i < m; i++) if (q_line[i] !== q_exp[i]) bad++;
    chk({tag, "_bits"}, bad, 0);
    chk({tag, "_ndone"}, q_done.size(), q_exp_done.size());
    m = (q_done.size() < q_exp_done.size()) ? q_done.size() : q_exp_done.size();
    for (int i = 0; i < m; i++) if (q_done[i] != q_exp_done[i]) dbad++;
    chk({tag, "_done_pos"}, dbad, 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    bit ok;
    int acc;
    int ones;
    int pb;
    int busy_cnt;
    logic [DBIT-1:0] w1;
    logic [DBIT-1:0] w2;
    logic [DBIT-1:0] words[$];
    logic [1:0] pm;
    logic st2;
    int n;

    cyc(3);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(tx_done_tick), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_count", int'(fifo_count), 0);
    rst = 1'b0;
    cyc(2);

    // 8N1 0xA5 with push-to-line latency.
    clear_all();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    cyc(1);
    in_valid = 1'b0;
    chk("lat_n1_busy", int'(busy), 0);
    chk("lat_n1_tx", int'(tx), 1);
    chk("lat_n1_count", int'(fifo_count), 1);
    cyc(1);
    chk("lat_n2_busy", int'(busy), 1);
    chk("lat_n2_tx", int'(tx), 0);
    chk("lat_n2_count", int'(fifo_count), 0);
    add_frame(8'hA5, 2'b00, 1'b0);
    wait_done(1, "a5");
    check_line("a5");
    chk("a5_cycles", q_line.size(), 160);

    // Even then odd parity on 0xA5.
    for (int m = 1; m <= 2; m++) begin
      clear_all();
      par_mode = 2'(m);
      push(8'hA5, ok);
      chk("par_push", int'(ok), 1);
      add_frame(8'hA5, 2'(m), 1'b0);
      wait_done(1, (m == 1) ? "even" : "odd");
      check_line((m == 1) ? "even" : "odd");
      pb = (q_line.size() > 144) ? int'(q_line[144]) : 2;
      chk((m == 1) ? "even_bit" : "odd_bit", pb, (m == 1 && PAR_BUILT) ? 0 : 1);
      chk((m == 1) ? "even_cycles" : "odd_cycles", q_line.size(), PAR_BUILT ? 176 : 160);
    end
    par_mode = 2'b00;

    // Two stop bits on 0x00.
    clear_all();
    stop2 = 1'b1;
    push(8'h00, ok);
    add_frame(8'h00, 2'b00, 1'b1);
    wait_done(1, "stop2");
    check_line("stop2");
    chk("stop2_cycles", q_line.size(), 176);
    ones = 0;
    for (int i = 144; i < 176; i++) if (i < q_line.size() && q_line[i]) ones++;
    chk("stop2_high", ones, 32);
    stop2 = 1'b0;

    // Backpressure with ticks stalled, then streaming.
    tick_mode = 1;
    cyc(2);
    clear_all();
    words.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = DBIT'($urandom);
      if (in_ready) words.push_back(in_data);
      cyc(1);
    end
    in_valid = 1'b0;
    acc = words.size();
    chk("bp_accepted", acc, DEPTH + 1);
    chk("bp_ready", int'(in_ready), 0);
    chk("bp_count", int'(fifo_count), DEPTH);
    foreach (words[i]) add_frame(words[i], 2'b00, 1'b0);
    gap_cnt    = 0;
    gap_target = acc;
    gap_en     = 1'b1;
    tick_den   = 2;
    tick_mode  = 2;
    wait_done(acc, "bp");
    gap_en = 1'b0;
    check_line("bp");
    chk("bp_gap", gap_cnt, 0);

    // Reset in the middle of the data bits of 0xFF.
    tick_mode = 0;
    cyc(2);
    clear_all();
    push(8'hFF, ok);
    push(8'h12, ok);
    push(8'h34, ok);
    cyc(66);
    chk("rstm_busy_before", int'(busy), 1);
    rst = 1'b1;
    cyc(1);
    chk("rstm_tx", int'(tx), 1);
    chk("rstm_count", int'(fifo_count), 0);
    chk("rstm_busy", int'(busy), 0);
    chk("rstm_ready", int'(in_ready), 1);
    rst = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (busy) busy_cnt++;
    end
    chk("rstm_stays_idle", busy_cnt, 0);
    chk("rstm_no_done", q_done.size(), 0);

    // Parity mode changed while the first of two queued frames is on the line.
    clear_all();
    w1 = DBIT'($urandom);
    w2 = DBIT'($urandom);
    push(w1, ok);
    push(w2, ok);
    cyc(20);
    par_mode = 2'b01;
    add_frame(w1, 2'b00, 1'b0);
    add_frame(w2, 2'b01, 1'b0);
    wait_done(2, "midpar");
    check_line("midpar");
    chk("midpar_f2_len", (q_done.size() == 2) ? q_done[1] - q_done[0] : -1, PAR_BUILT ? 176 : 160);
    par_mode = 2'b00;

    // Randomised batches, format fixed per batch.
    for (int b = 0; b < 6; b++) begin
      clear_all();
      pm        = 2'($urandom % 4);
      st2       = 1'($urandom % 2);
      par_mode  = pm;
      stop2     = st2;
      tick_den  = 1 + ($urandom % 3);
      tick_mode = 2;
      n = 1 + ($urandom % 6);
      for (int k = 0; k < n; k++) begin
        cyc($urandom % 3);
        w1 = DBIT'($urandom);
        push(w1, ok);
        chk($sformatf("rnd%0d_push", b), int'(ok), 1);
        if (ok) add_frame(w1, pm, st2);
      end
      wait_done(n, $sformatf("rnd%0d", b));
      check_line($sformatf("rnd%0d", b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter with an input FIFO and runtime-selectable frame format: data width, parity (none/even/odd) and one or two stop bits. Sits between the byte-producing logic and the serial pin. Shares the baud generator's `s_tick` oversampling strobe with the receiver. Replaces the fixed 8N1 transmitter and its single-cycle `tx_start` pulse with a valid/ready push interface and back-to-back frame streaming.

## Interface

**Parameters**
- `DBIT`, default 8: data bits per frame, 5..9, sent LSB first.
- `OS_TICK`, default 16: `s_tick` pulses per bit period, 2..64.
- `FIFO_DEPTH`, default 4: input FIFO entries, power of two ≥2.

**Ports** (clock and reset first)
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `s_tick`, in, 1: oversampling strobe, one `clk` cycle wide.
- `in_valid`, in, 1: producer has a word on `in_data`.
- `in_data`, in, DBIT: word to send.
- `in_ready`, out, 1: equals `!fifo_full`. A push occurs when `in_valid && in_ready`.
- `par_mode`, in, 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `stop2`, in, 1: 1 selects two stop bits.
- `tx`, out, 1: serial line, registered, idles high.
- `busy`, out, 1: a frame is in progress (state ≠ IDLE).
- `tx_done_tick`, out, 1: one-cycle pulse when the last stop bit completes.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `tx`=1.
  - If the FIFO is non-empty, pop the head into the shift register.
  - In the same cycle, latch `par_mode` and `stop2` into frame registers, then go to START.
  - `par_mode`/`stop2` changes mid-frame affect the next frame only.
- **START:** `tx`=0 for OS_TICK ticks, then DATA with bit counter = 0.
- **DATA:**
  - `tx` = shift[0], held for OS_TICK ticks.
  - Then shift right and increment the bit counter.
  - After bit DBIT-1, go to PARITY if the latched mode is even/odd, otherwise STOP.
- **PARITY:** `tx` = XOR of the latched word for even, or its inverse for odd. Held for OS_TICK ticks, then STOP.
- **STOP:**
  - `tx`=1 for OS_TICK ticks, or 2·OS_TICK ticks when `stop2` was latched.
  - On completion, pulse `tx_done_tick`.
  - If the FIFO is non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- The tick counter advances only on cycles with `s_tick`=1. It is cleared on every state change.
- FIFO behaviour:
  - A push while full is dropped (`in_ready` is already low).
  - A push and a pop in the same cycle are both performed, and the count is unchanged.
  - A word pushed into an empty FIFO is poppable from the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing

- Reset values: `tx`=1, `busy`=0, `tx_done_tick`=0, `in_ready`=1, `fifo_count`=0, state IDLE. The FIFO is flushed.
- Reset asserted mid-frame: `tx` is high on the cycle after the reset edge, and the partial frame is abandoned without a `tx_done_tick`.
- Latency from a push (cycle N, FIFO empty, IDLE):
  - Pop in N+1.
  - `tx` falls at N+2 and `busy`=1 at N+2.
- Frame length in ticks is OS_TICK·(1 + DBIT + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- `tx_done_tick` asserts in the cycle the FSM leaves STOP.

## Configuration

- Macro `UART_TX_FRAME_PARITY_EN`.
  - **Defined:** the PARITY state and parity logic are built, and `par_mode` behaves as above.
  - **Undefined:** the PARITY state, its logic and its frame-register bit are removed. `par_mode` is accepted and ignored, and frames never carry a parity bit.

## Structure

- Shared package `uart_pkg` holds:
  - state encoding constants (IDLE=0 … STOP=4);
  - parity mode constants PAR_NONE, PAR_EVEN and PAR_ODD.
- One sub-module, `uart_sync_fifo`: parameterised on width and depth, single clock, synchronous active-high reset. The receiver reuses it.

## Test plan

- Reset, then DBIT=8, OS_TICK=16, `s_tick` every cycle, `par_mode`=00, `stop2`=0, push 0xA5.
  - Required: `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each level lasting 16 cycles (160 cycles total).
  - Required: exactly one `tx_done_tick`.
- 0xA5 with even, then odd parity.
  - Required: the parity bit is 0 for even and 1 for odd.
  - Required: the frame is 176 cycles.
  - With the macro undefined: still 160 cycles.
- `stop2`=1, no parity, push 0x00.
  - Required: `tx` is high for 32 cycles after the last data bit.
  - Required: the frame is 176 cycles.
- Hold `s_tick`=0, push continuously.
  - Required: exactly FIFO_DEPTH+1 = 5 words are accepted, then `in_ready`=0 and `fifo_count`=4.
  - Release `s_tick`: required result is 5 consecutive frames with no idle gap and 5 `tx_done_tick` pulses.
- Assert `rst` during DATA of 0xFF.
  - Required: `tx`=1 on the next cycle, `fifo_count`=0, and no `tx_done_tick`.
- Change `par_mode` from 00 to 01 mid-frame.
  - Required: the current frame has no parity bit, and the next queued frame carries one.
